// File: rtl/bus_cmd_master_pkg.sv
// Shared constants and types for the host-link bus initiator.
// Holds the command opcodes, the response bytes, the burst count width
// and the controller state encoding used by bus_cmd_master.
package bus_cmd_master_pkg;

   // Command opcodes received from the host link
   localparam logic [7:0] OP_WRITE = 8'h57;
   localparam logic [7:0] OP_READ  = 8'h52;

   // Single-byte responses sent back to the host link
   localparam logic [7:0] RSP_ACK  = 8'h4B;
   localparam logic [7:0] RSP_ERR  = 8'h3F;

   // Nine bits so that a count byte of zero can stand for 256
   localparam int CountWidth = 9;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_COUNT,
      S_WR_DATA,
      S_WR_GNT,
      S_WR_STB,
      S_RD_GNT,
      S_RD_ADR,
      S_RD_LAT,
      S_RD_SEND,
      S_ACK,
      S_ERR
   } state_t;

endpackage

// File: rtl/bus_cmd_timeout.sv
// Inter-byte inactivity timer for the command parser.
// Ports:
//   clk_i, reset_i : clock and asynchronous active-high reset
//   clear          : reload the full interval (a byte arrived, or not parsing)
//   enable         : count down this cycle
//   expire         : the interval has run out while enabled
module bus_cmd_timeout #(
   parameter int Cycles = 50000000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CountW = $clog2(Cycles + 1);

   logic [CountW-1:0] remaining;

   // Down-counter loaded with Cycles-1 so that expire fires on the
   // Cycles-th enabled cycle after the last clear; it parks at zero.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         remaining <= CountW'(Cycles - 1);
      end else if (clear) begin
         remaining <= CountW'(Cycles - 1);
      end else if (enable && (remaining != '0)) begin
         remaining <= remaining - CountW'(1);
      end
   end

   // A clear in the same cycle wins, since a fresh byte means activity
   assign expire = enable && !clear && (remaining == '0);

endmodule

// File: rtl/bus_cmd_master.sv
// Byte-stream driven bus initiator used by the host link to peek and poke
// memory and peripherals on the CPU bus.
// Ports:
//   clk_i, reset_i            : clock and asynchronous active-high reset
//   rx_data_i/valid_i/ready_o : incoming command bytes
//   tx_data_o/valid_o/ready_i : outgoing response bytes
//   bus_req_o, bus_gnt_i      : bus ownership handshake with the top level
//   address_o, data_o, rd_wr_o: bus cycle drive, zero when not in a cycle
//   data_i                    : muxed bus read data
module bus_cmd_master
   import bus_cmd_master_pkg::*;
#(
   parameter int address_width = 16,
   parameter int data_width    = 8,
   parameter int ReadLatency   = 1,
   parameter int TimeoutCycles = 50000000
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [7:0]               rx_data_i,
   input  logic                     rx_valid_i,
   output logic                     rx_ready_o,
   output logic [7:0]               tx_data_o,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic                     bus_req_o,
   input  logic                     bus_gnt_i,
   output logic [address_width-1:0] address_o,
   output logic [data_width-1:0]    data_o,
   input  logic [data_width-1:0]    data_i,
   output logic                     rd_wr_o
);

   localparam int LatW = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;

   state_t                  state;
   state_t                  next_state;
   logic [address_width-1:0] addr;
   logic [CountWidth-1:0]   count;
   logic [data_width-1:0]   wdata;
   logic                    is_write;
   logic [LatW-1:0]         lat_cnt;
   logic                    rx_fire;
   logic                    tx_fire;
   logic                    last_byte;
   logic                    lat_done;
   logic                    parsing;
   logic                    expired;

   assign rx_fire   = rx_valid_i && rx_ready_o;
   assign tx_fire   = tx_valid_o && tx_ready_i;
   assign last_byte = (count == CountWidth'(1));
   assign lat_done  = (lat_cnt == LatW'(ReadLatency - 1));
   assign parsing   = (state == S_ADDR_HI) || (state == S_ADDR_LO) ||
                      (state == S_COUNT)   || (state == S_WR_DATA);

   // The timer only runs while a partially received command is pending;
   // outside those states it is held at its reload value.
   bus_cmd_timeout #(
      .Cycles (TimeoutCycles)
   ) u_timeout (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear   (rx_fire || !parsing),
      .enable  (parsing),
      .expire  (expired)
   );

   // State register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic plus all state-decoded outputs. Bus drive lines are
   // zero outside an active cycle so the top level can OR/mux them safely.
   // A byte arriving on the same cycle as a timeout is still accepted.
   always_comb begin
      next_state = state;
      rx_ready_o = 1'b0;
      tx_valid_o = 1'b0;
      bus_req_o  = 1'b0;
      address_o  = '0;
      data_o     = '0;
      rd_wr_o    = 1'b0;
      case (state)
         S_IDLE: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i) begin
               if ((rx_data_i == OP_WRITE) || (rx_data_i == OP_READ)) begin
                  next_state = S_ADDR_HI;
               end else begin
                  next_state = S_ERR;
               end
            end
         end
         S_ADDR_HI: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i)   next_state = S_ADDR_LO;
            else if (expired) next_state = S_IDLE;
         end
         S_ADDR_LO: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i)   next_state = S_COUNT;
            else if (expired) next_state = S_IDLE;
         end
         S_COUNT: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i)   next_state = is_write ? S_WR_DATA : S_RD_GNT;
            else if (expired) next_state = S_IDLE;
         end
         S_WR_DATA: begin
            rx_ready_o = 1'b1;
            if (rx_valid_i)   next_state = S_WR_GNT;
            else if (expired) next_state = S_IDLE;
         end
         S_WR_GNT: begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) next_state = S_WR_STB;
         end
         S_WR_STB: begin
            bus_req_o  = 1'b1;
            address_o  = addr;
            data_o     = wdata;
            rd_wr_o    = 1'b1;
            next_state = last_byte ? S_ACK : S_WR_DATA;
         end
         S_RD_GNT: begin
            bus_req_o = 1'b1;
            if (bus_gnt_i) next_state = S_RD_ADR;
         end
         S_RD_ADR: begin
            bus_req_o  = 1'b1;
            address_o  = addr;
            next_state = S_RD_LAT;
         end
         S_RD_LAT: begin
            bus_req_o = 1'b1;
            address_o = addr;
            if (lat_done) next_state = S_RD_SEND;
         end
         S_RD_SEND: begin
            tx_valid_o = 1'b1;
            if (tx_ready_i) next_state = last_byte ? S_IDLE : S_RD_GNT;
         end
         S_ACK, S_ERR: begin
            tx_valid_o = 1'b1;
            if (tx_ready_i) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Command fields, burst address/count bookkeeping and the response byte.
   // The response register only changes when a new byte is about to be
   // presented, which keeps tx_data_o stable under backpressure. Read data
   // is captured on the last latency cycle, ReadLatency cycles after the
   // address first appeared.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         addr      <= '0;
         count     <= '0;
         wdata     <= '0;
         is_write  <= 1'b0;
         lat_cnt   <= '0;
         tx_data_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rx_fire) begin
                  is_write <= (rx_data_i == OP_WRITE);
                  if ((rx_data_i != OP_WRITE) && (rx_data_i != OP_READ)) begin
                     tx_data_o <= RSP_ERR;
                  end
               end
            end
            S_ADDR_HI: if (rx_fire) addr <= address_width'({rx_data_i, addr[7:0]});
            S_ADDR_LO: if (rx_fire) addr <= address_width'({addr[address_width-1:8], rx_data_i});
            S_COUNT: begin
               if (rx_fire) begin
                  count <= (rx_data_i == 8'd0) ? CountWidth'(256) : CountWidth'(rx_data_i);
               end
            end
            S_WR_DATA: if (rx_fire) wdata <= data_width'(rx_data_i);
            S_WR_STB: begin
               addr  <= addr + address_width'(1);
               count <= count - CountWidth'(1);
               if (last_byte) tx_data_o <= RSP_ACK;
            end
            S_RD_ADR: lat_cnt <= '0;
            S_RD_LAT: begin
               lat_cnt <= lat_cnt + LatW'(1);
               if (lat_done) tx_data_o <= 8'(data_i);
            end
            S_RD_SEND: begin
               if (tx_fire) begin
                  addr  <= addr + address_width'(1);
                  count <= count - CountWidth'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Self-checking bench for bus_cmd_master: directed host commands, a small
// bus memory with one cycle of read latency, and a scoreboard monitor that
// checks every response byte and every bus write against queued expectations.
module tb_bus_cmd_master;

   logic        clk;
   logic        reset_i;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready;
   logic        bus_req_o;
   logic        gnt_en;
   logic [15:0] address_o;
   logic [7:0]  data_o;
   logic [7:0]  rd_q;
   logic        rd_wr_o;

   logic [7:0]  mem [0:65535];
   logic [7:0]  exp_tx [$];
   logic [23:0] exp_wr [$];
   int          checks = 0;
   int          errors = 0;
   logic        prev_stall;
   logic [7:0]  prev_data;

   bus_cmd_master #(
      .address_width (16),
      .data_width    (8),
      .ReadLatency   (1),
      .TimeoutCycles (100)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .rx_data_i  (rx_data),
      .rx_valid_i (rx_valid),
      .rx_ready_o (rx_ready_o),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready),
      .bus_req_o  (bus_req_o),
      .bus_gnt_i  (gnt_en),
      .address_o  (address_o),
      .data_o     (data_o),
      .data_i     (rd_q),
      .rd_wr_o    (rd_wr_o)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bus memory: registered read data gives one cycle of latency
   always @(posedge clk) begin
      rd_q <= mem[address_o];
      if (rd_wr_o) mem[address_o] <= data_o;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic flagUnexpected(input string name, input logic [31:0] actual);
      checks++;
      errors++;
      $display("[TB] FAIL %s got %h expected nothing at %0t", name, actual, $time);
   endtask

   // Scoreboard monitor, sampling on the falling edge
   always @(negedge clk) begin
      if (reset_i) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("tx_hold_valid", 32'(tx_valid_o), 32'd1);
            checkOutput("tx_hold_data", 32'(tx_data_o), 32'(prev_data));
         end
         if (tx_valid_o && !tx_ready) checkOutput("req_while_stalled", 32'(bus_req_o), 32'd0);
         if (tx_valid_o && tx_ready) begin
            if (exp_tx.size() == 0) flagUnexpected("tx_unexpected", 32'(tx_data_o));
            else checkOutput("tx_byte", 32'(tx_data_o), 32'(exp_tx.pop_front()));
         end
         if (rd_wr_o) begin
            if (exp_wr.size() == 0) flagUnexpected("wr_unexpected", {8'h0, address_o, data_o});
            else checkOutput("wr_cycle", {8'h0, address_o, data_o}, 32'(exp_wr.pop_front()));
         end
         prev_stall <= tx_valid_o && !tx_ready;
         prev_data  <= tx_data_o;
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Offers one command byte and waits (bounded) until it is accepted
   task automatic applyStimulus(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready_o && n < 2000) begin
         stepCycle();
         n++;
      end
      if (!rx_ready_o) flagUnexpected("rx_accept_timeout", 32'(b));
      stepCycle();
      rx_valid = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while ((exp_tx.size() != 0 || exp_wr.size() != 0) && n < 3000) begin
         stepCycle();
         n++;
      end
      checkOutput(name, 32'(exp_tx.size() + exp_wr.size()), 32'd0);
      repeat (5) stepCycle();
   endtask

   initial begin
      reset_i  = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      gnt_en   = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0300] = 8'h11;
      mem[16'h0301] = 8'h22;
      mem[16'hFFFF] = 8'hA5;
      mem[16'h0000] = 8'h5A;
      #1;
      checkOutput("rst_rx_ready", 32'(rx_ready_o), 32'd1);
      checkOutput("rst_tx_valid", 32'(tx_valid_o), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data_o), 32'd0);
      checkOutput("rst_bus_req", 32'(bus_req_o), 32'd0);
      checkOutput("rst_address", 32'(address_o), 32'd0);
      checkOutput("rst_data", 32'(data_o), 32'd0);
      checkOutput("rst_rd_wr", 32'(rd_wr_o), 32'd0);
      repeat (3) stepCycle();
      reset_i = 1'b0;
      stepCycle();

      $display("[TB] two-byte write");
      exp_wr.push_back({16'h1234, 8'hAA});
      exp_wr.push_back({16'h1235, 8'hBB});
      exp_tx.push_back(8'h4B);
      applyStimulus(8'h57); applyStimulus(8'h12); applyStimulus(8'h34);
      applyStimulus(8'h02); applyStimulus(8'hAA); applyStimulus(8'hBB);
      waitDrain("drain_write");

      $display("[TB] read with host backpressure");
      exp_tx.push_back(8'h11);
      exp_tx.push_back(8'h22);
      tx_ready = 1'b0;
      applyStimulus(8'h52); applyStimulus(8'h03); applyStimulus(8'h00); applyStimulus(8'h02);
      for (int k = 0; k < 2; k++) begin
         int n = 0;
         while (!tx_valid_o && n < 200) begin
            stepCycle();
            n++;
         end
         checkOutput("stall_tx_appears", 32'(tx_valid_o), 32'd1);
         repeat (10) stepCycle();
         tx_ready = 1'b1;
         stepCycle();
         tx_ready = 1'b0;
      end
      tx_ready = 1'b1;
      waitDrain("drain_stall_read");

      $display("[TB] read across address wrap");
      exp_tx.push_back(8'hA5);
      exp_tx.push_back(8'h5A);
      applyStimulus(8'h52); applyStimulus(8'hFF); applyStimulus(8'hFF); applyStimulus(8'h02);
      waitDrain("drain_wrap_read");

      $display("[TB] unknown opcode");
      exp_tx.push_back(8'h3F);
      applyStimulus(8'h41);
      waitDrain("drain_unknown");

      $display("[TB] 256-byte write burst");
      for (int i = 0; i < 256; i++) exp_wr.push_back({16'h0010 + 16'(i), 8'(i)});
      exp_tx.push_back(8'h4B);
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h10); applyStimulus(8'h00);
      for (int i = 0; i < 256; i++) applyStimulus(8'(i));
      waitDrain("drain_burst");

      $display("[TB] partial command timeout");
      applyStimulus(8'h57); applyStimulus(8'h00);
      repeat (150) stepCycle();
      checkOutput("timeout_no_req", 32'(bus_req_o), 32'd0);
      exp_tx.push_back(8'h11);
      applyStimulus(8'h52); applyStimulus(8'h03); applyStimulus(8'h00); applyStimulus(8'h01);
      waitDrain("drain_after_timeout");

      $display("[TB] write waits for grant");
      gnt_en = 1'b0;
      applyStimulus(8'h57); applyStimulus(8'h00); applyStimulus(8'h20);
      applyStimulus(8'h01); applyStimulus(8'h77);
      repeat (20) stepCycle();
      checkOutput("gnt_wait_req", 32'(bus_req_o), 32'd1);
      exp_wr.push_back({16'h0020, 8'h77});
      exp_tx.push_back(8'h4B);
      gnt_en = 1'b1;
      waitDrain("drain_gnt_write");

      $display("[TB] reset during read latency");
      applyStimulus(8'h52); applyStimulus(8'h03); applyStimulus(8'h00); applyStimulus(8'h02);
      begin
         int n = 0;
         while (address_o != 16'h0300 && n < 50) begin
            stepCycle();
            n++;
         end
      end
      checkOutput("rd_adr_seen", 32'(address_o), 32'h0300);
      stepCycle();
      reset_i = 1'b1;
      #1;
      checkOutput("midrst_bus_req", 32'(bus_req_o), 32'd0);
      checkOutput("midrst_address", 32'(address_o), 32'd0);
      checkOutput("midrst_tx_valid", 32'(tx_valid_o), 32'd0);
      stepCycle();
      checkOutput("midrst_next_req", 32'(bus_req_o), 32'd0);
      reset_i = 1'b0;
      stepCycle();
      exp_tx.push_back(8'h22);
      applyStimulus(8'h52); applyStimulus(8'h03); applyStimulus(8'h01); applyStimulus(8'h01);
      waitDrain("drain_after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
